// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pc_incr.sv
// pc_incr: sequential next-PC adder; wraps modulo 2^32.
module pc_incr
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o
);

    assign pc_next_o = pc_i + PC_STEP;

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC sequencer issuing one imem fetch at a time, with redirect and stale-response kill.
// Define PC_FETCH_MISALIGN_CHK_EN to reject and flag redirect targets that are not word aligned.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        misalign_o,
    output logic [31:0] misalign_pc_o
);

    state_e      state_q;
    logic [31:0] pc_q, req_addr_q, if_pc_q, if_instr_q, pc_inc, tgt;
    logic        kill_q, if_valid_q, bad, redir;

    pc_incr u_incr (.pc_i(pc_q), .pc_next_o(pc_inc));

`ifdef PC_FETCH_MISALIGN_CHK_EN
    logic        mis_q;
    logic [31:0] mis_pc_q;
    assign bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign tgt = redirect_pc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q    <= 1'b0;
            mis_pc_q <= '0;
        end else begin
            mis_q    <= bad;
            mis_pc_q <= bad ? redirect_pc : '0;
        end
    end
    assign misalign_o    = mis_q;
    assign misalign_pc_o = mis_pc_q;
`else
    assign bad           = 1'b0;
    assign tgt           = redirect_pc & ~32'd3;
    assign misalign_o    = 1'b0;
    assign misalign_pc_o = '0;
`endif

    assign redir = redirect_valid && !bad;

    // req_addr_q is loaded only when entering S_REQ so a pending request never changes address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_REQ;
                    pc_q       <= redir ? tgt : pc_q;
                    req_addr_q <= redir ? tgt : pc_q;
                end
                S_REQ: begin
                    if (imem_req_ready) state_q <= S_WAIT;
                    if (redir) begin
                        pc_q   <= tgt;
                        kill_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (redir || kill_q) begin
                            pc_q       <= redir ? tgt : pc_q;
                            req_addr_q <= redir ? tgt : pc_q;
                            kill_q     <= 1'b0;
                            state_q    <= S_REQ;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_pc_q    <= pc_q;
                            if_instr_q <= imem_rsp_data;
                            state_q    <= S_HOLD;
                        end
                    end else if (redir) begin
                        pc_q   <= tgt;
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redir || if_ready) begin
                        if_valid_q <= 1'b0;
                        pc_q       <= redir ? tgt : pc_inc;
                        req_addr_q <= redir ? tgt : pc_inc;
                        state_q    <= S_REQ;
                    end
                end
            endcase
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = req_addr_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed and random fetch traffic against a transaction-level model of the fetch stream.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    logic        if_ready = 1'b0;
    logic        misalign_o;
    logic [31:0] misalign_pc_o;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .misalign_o(misalign_o), .misalign_pc_o(misalign_pc_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc_no = 0, req_cyc = 0, lat = 1, cnt = 0;
    logic [31:0] next_pc, req_pc, hold_pc, hold_instr, mis_pc_exp, prev_addr, paddr;
    logic outst, stale, exp_dlv, exp_mis, prev_pend, prev_held, fast, pend, rdy_rand, lat_rand;

    // instruction memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_if_pc"}, if_pc, 32'd0);
        chk({tag, "_if_instr"}, if_instr, 32'h0000_0013);
        chk({tag, "_misalign"}, 32'(misalign_o), 32'd0);
        chk({tag, "_misalign_pc"}, misalign_pc_o, 32'd0);
    endtask

    task automatic model_reset;
        next_pc = RST_PC; outst = 0; stale = 0; exp_dlv = 0; exp_mis = 0; mis_pc_exp = '0;
        prev_pend = 0; prev_held = 0; pend = 0; cnt = 0;
    endtask

    // one clock: observe outputs at the falling edge, check them, then drive inputs and advance the model
    task automatic cyc(input logic rv, input logic [31:0] rpc, input logic ir);
        logic bad, redir;
        logic [31:0] tgt;
        @(negedge clk);
        cyc_no++;
        chk("if_valid", 32'(if_valid), 32'(exp_dlv || prev_held));
        if (exp_dlv) begin
            chk("if_pc", if_pc, req_pc);
            chk("if_instr", if_instr, mem(req_pc));
            if (fast) chk("latency", 32'(cyc_no - req_cyc), 32'd2);
        end
        if (prev_held) begin
            chk("hold_pc", if_pc, hold_pc);
            chk("hold_instr", if_instr, hold_instr);
        end
        chk("misalign", 32'(misalign_o), 32'(exp_mis));
        chk("misalign_pc", misalign_pc_o, mis_pc_exp);
        chk("req_during_hold", 32'(imem_req_valid && if_valid), 32'd0);
        if (prev_pend) begin
            chk("pend_valid", 32'(imem_req_valid), 32'd1);
            chk("pend_addr", imem_req_addr, prev_addr);
        end else if (imem_req_valid) begin
            chk("req_addr", imem_req_addr, next_pc);
            req_pc = imem_req_addr; outst = 1; stale = 0; req_cyc = cyc_no;
        end
        imem_rsp_valid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1; imem_rsp_data = mem(paddr); pend = 0;
            end
        end
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (imem_req_valid && imem_req_ready) begin
            pend = 1; paddr = imem_req_addr;
            cnt = lat_rand ? int'($urandom_range(1, 3)) : lat;
        end
        redirect_valid = rv; redirect_pc = rpc; if_ready = ir;
`ifdef PC_FETCH_MISALIGN_CHK_EN
        bad = rv && (rpc[1:0] != 2'b00);
        tgt = rpc;
`else
        bad = 1'b0;
        tgt = {rpc[31:2], 2'b00};
`endif
        redir = rv && !bad;
        exp_mis = bad;
        mis_pc_exp = bad ? rpc : 32'd0;
        if (redir && outst) stale = 1;
        exp_dlv = imem_rsp_valid && outst && !stale;
        if (imem_rsp_valid) outst = 0;
        prev_held = if_valid && !ir && !redir;
        hold_pc = if_pc; hold_instr = if_instr;
        if (redir) next_pc = tgt;
        else if (if_valid && ir) next_pc = if_pc + 32'd4;
        prev_pend = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
    endtask

    task automatic wait_hold;
        for (int i = 0; i < 30 && !if_valid; i++) cyc(1'b0, 32'd0, 1'b0);
        chk("wait_if_valid", 32'(if_valid), 32'd1);
    endtask

    initial begin
        rdy_rand = 0; lat_rand = 0; fast = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        if_ready = 1'b1;
        fast = 1;
        repeat (12) cyc(1'b0, 32'd0, 1'b1);
        fast = 0;
        wait_hold();
        repeat (5) cyc(1'b0, 32'd0, 1'b0);
        repeat (6) cyc(1'b0, 32'd0, 1'b1);
        lat = 3;
        for (int i = 0; i < 30 && !imem_req_valid; i++) cyc(1'b0, 32'd0, 1'b1);
        chk("wait_req", 32'(imem_req_valid), 32'd1);
        cyc(1'b0, 32'd0, 1'b1);
        cyc(1'b1, 32'h0000_0200, 1'b1);
        repeat (12) cyc(1'b0, 32'd0, 1'b1);
        lat = 1;
        wait_hold();
        cyc(1'b1, 32'h0000_0300, 1'b1);
        repeat (6) cyc(1'b0, 32'd0, 1'b1);
        wait_hold();
        cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (10) cyc(1'b0, 32'd0, 1'b1);
        cyc(1'b1, 32'h0000_0202, 1'b1);
        repeat (8) cyc(1'b0, 32'd0, 1'b1);
        rdy_rand = 1; lat_rand = 1;
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 9) == 0), $urandom, 1'($urandom_range(0, 2) != 0));
        rst_n = 1'b0;
        #1 chk_reset("mid_reset");
        model_reset();
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        rdy_rand = 0; lat_rand = 0; lat = 1;
        repeat (10) cyc(1'b0, 32'd0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
